// File: rtl/idecode_pkg.sv
// idecode_pkg: ALU function codes, RV32I opcodes and decode types shared by idecode, imm_gen and the ALU.
package idecode_pkg;
  localparam logic [3:0] FN_ADD  = 4'h0;
  localparam logic [3:0] FN_SLL  = 4'h1;
  localparam logic [3:0] FN_SLT  = 4'h2;
  localparam logic [3:0] FN_SLTU = 4'h3;
  localparam logic [3:0] FN_XOR  = 4'h4;
  localparam logic [3:0] FN_SRL  = 4'h5;
  localparam logic [3:0] FN_OR   = 4'h6;
  localparam logic [3:0] FN_AND  = 4'h7;
  localparam logic [3:0] FN_SUB  = 4'h8;
  localparam logic [3:0] FN_SRA  = 4'hd;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [2:0] {IMM_N, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SH} imm_t;

  typedef struct packed {
    logic [3:0]  fn;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        use_pc;
    logic        illegal;
    logic [31:0] pc;
  } dec_t;
endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational RV32I immediate extraction; shifts yield the zero-extended shamt.
module imm_gen
  import idecode_pkg::*;
(
  input  logic [31:7] instr,
  input  imm_t        typ,
  output logic [31:0] imm
);
  always_comb
    imm = typ == IMM_I  ? {{20{instr[31]}}, instr[31:20]} :
          typ == IMM_S  ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
          typ == IMM_B  ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
          typ == IMM_U  ? {instr[31:12], 12'b0} :
          typ == IMM_J  ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
          typ == IMM_SH ? {27'b0, instr[24:20]} : '0;
endmodule

// File: rtl/idecode.sv
// idecode: RV32I decode stage, one-cycle registered output with valid/ready handshake.
// Define IDECODE_SKID_EN to add a one-entry skid buffer so in_ready no longer depends on out_ready.
module idecode
  import idecode_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_fn,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic [31:0] out_imm,
  output logic        out_use_imm,
  output logic        out_use_pc,
  output logic [31:0] out_pc,
  output logic        out_illegal
);
  logic [2:0]  f3;
  logic        f7b;
  imm_t        ityp;
  logic [31:0] imm;
  dec_t        dec_n, dec, out_q, out_d;
  logic        valid_q, valid_d, accept;

  assign f3  = in_instr[14:12];
  assign f7b = in_instr[30];

  imm_gen u_imm (.instr(in_instr[31:7]), .typ(ityp), .imm(imm));

  always_comb begin
    dec_n     = '0;
    dec_n.rs1 = in_instr[19:15];
    dec_n.rs2 = in_instr[24:20];
    dec_n.rd  = in_instr[11:7];
    dec_n.pc  = in_pc;
    ityp      = IMM_N;
    case (in_instr[6:0])
      OP_OP:     dec_n.fn = f7b && f3 == 3'd0 ? FN_SUB : f7b && f3 == 3'd5 ? FN_SRA : {1'b0, f3};
      OP_IMM: begin
        dec_n.fn      = f3 == 3'd5 && f7b ? FN_SRA : {1'b0, f3};
        dec_n.use_imm = 1'b1;
        ityp          = f3 == 3'd1 || f3 == 3'd5 ? IMM_SH : IMM_I;
      end
      OP_LUI: begin
        dec_n.rs1     = '0;
        dec_n.use_imm = 1'b1;
        ityp          = IMM_U;
      end
      OP_AUIPC: begin
        dec_n.use_imm = 1'b1;
        dec_n.use_pc  = 1'b1;
        ityp          = IMM_U;
      end
      OP_LOAD, OP_JALR: begin
        dec_n.use_imm = 1'b1;
        ityp          = IMM_I;
      end
      OP_STORE: begin
        dec_n.use_imm = 1'b1;
        ityp          = IMM_S;
      end
      OP_JAL:    ityp = IMM_J;
      OP_BRANCH: begin
        dec_n.fn      = f3[2:1] == 2'b00 ? FN_SUB : f3[2:1] == 2'b10 ? FN_SLT : FN_SLTU;
        dec_n.illegal = f3[2:1] == 2'b01;
        ityp          = IMM_B;
      end
      default:   dec_n.illegal = 1'b1;
    endcase
    // illegal words still flow downstream, but as a harmless add with no immediate
    if (dec_n.illegal) begin
      dec_n.fn      = FN_ADD;
      dec_n.use_imm = 1'b0;
      ityp          = IMM_N;
    end
  end

  always_comb begin
    dec     = dec_n;
    dec.imm = imm;
  end

`ifdef IDECODE_SKID_EN
  dec_t skid_q, skid_d;
  logic skid_full_q, skid_full_d;

  assign in_ready = !rst && !skid_full_q;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    valid_d     = valid_q;
    out_d       = out_q;
    skid_d      = skid_q;
    skid_full_d = skid_full_q;
    if (flush) begin
      valid_d     = 1'b0;
      skid_full_d = 1'b0;
    end else if (!valid_q || out_ready) begin
      valid_d     = skid_full_q || accept;
      out_d       = skid_full_q ? skid_q : accept ? dec : out_q;
      skid_full_d = 1'b0;
    end else if (accept) begin
      skid_d      = dec;
      skid_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk)
    if (rst) begin
      skid_full_q <= 1'b0;
      skid_q      <= '0;
    end else begin
      skid_full_q <= skid_full_d;
      skid_q      <= skid_d;
    end
`else
  assign in_ready = !rst && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    valid_d = valid_q;
    out_d   = out_q;
    if (flush) valid_d = 1'b0;
    else if (!valid_q || out_ready) begin
      valid_d = accept;
      out_d   = accept ? dec : out_q;
    end
  end
`endif

  always_ff @(posedge clk)
    if (rst) begin
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      valid_q <= valid_d;
      out_q   <= out_d;
    end

  // masked during reset so a held word cannot transfer on the reset edge
  assign out_valid   = valid_q && !rst;
  assign out_fn      = out_q.fn;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_rd      = out_q.rd;
  assign out_imm     = out_q.imm;
  assign out_use_imm = out_q.use_imm;
  assign out_use_pc  = out_q.use_pc;
  assign out_pc      = out_q.pc;
  assign out_illegal = out_q.illegal;
endmodule

// File: tb/tb_idecode.sv
// tb_idecode: scoreboard bench for idecode; directed vectors with hand-computed decode results.
module tb_idecode;
  typedef struct packed {
    logic [3:0]  fn;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        ui;
    logic        up;
    logic        il;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic        in_ready, out_valid, out_use_imm, out_use_pc, out_illegal;
  logic [3:0]  out_fn;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_imm, out_pc;
  exp_t        act;
  exp_t        q[$];
  int          errors = 0, checks = 0;

  always #5 clk = ~clk;

  idecode dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_fn(out_fn), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_use_imm(out_use_imm), .out_use_pc(out_use_pc),
    .out_pc(out_pc), .out_illegal(out_illegal)
  );

  assign act = {out_fn, out_rs1, out_rs2, out_rd, out_imm, out_use_imm, out_use_pc, out_illegal, out_pc};

  function automatic exp_t e(input logic [3:0] fn, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic [31:0] imm, input logic ui,
                             input logic up, input logic il, input logic [31:0] pc);
    return {fn, rs1, rs2, rd, imm, ui, up, il, pc};
  endfunction

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, x);
    end
  endtask

  // called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [31:0] ins, input logic [31:0] pc, input exp_t ex, input bit push);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) chk("send_timeout", 128'(in_ready), 128'(1));
    else if (push) q.push_back(ex);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  always @(negedge clk)
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %h expected none", act);
      end else chk("out", 128'(act), 128'(q.pop_front()));
    end

  initial begin
    exp_t ha;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", 128'(out_valid), 128'(0));
    chk("reset_fields", 128'(act), 128'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
    send(32'h002081B3, 32'h100, e(4'h0, 5'd1, 5'd2, 5'd3, 32'h0, 0, 0, 0, 32'h100), 1);
    send(32'h402081B3, 32'h104, e(4'h8, 5'd1, 5'd2, 5'd3, 32'h0, 0, 0, 0, 32'h104), 1);
    send(32'h40335293, 32'h108, e(4'hd, 5'd6, 5'd3, 5'd5, 32'h3, 1, 0, 0, 32'h108), 1);
    send(32'h123450B7, 32'h10C, e(4'h0, 5'd0, 5'd3, 5'd1, 32'h12345000, 1, 0, 0, 32'h10C), 1);
    send(32'h00000000, 32'h110, e(4'h0, 5'd0, 5'd0, 5'd0, 32'h0, 0, 0, 1, 32'h110), 1);
    send(32'hFFF00093, 32'h114, e(4'h0, 5'd0, 5'd31, 5'd1, 32'hFFFFFFFF, 1, 0, 0, 32'h114), 1);
    send(32'h00209463, 32'h118, e(4'h8, 5'd1, 5'd2, 5'd8, 32'h8, 0, 0, 0, 32'h118), 1);
    send(32'h0020F463, 32'h11C, e(4'h3, 5'd1, 5'd2, 5'd8, 32'h8, 0, 0, 0, 32'h11C), 1);
    send(32'h0020A463, 32'h120, e(4'h0, 5'd1, 5'd2, 5'd8, 32'h0, 0, 0, 1, 32'h120), 1);
    send(32'hFE20AE23, 32'h124, e(4'h0, 5'd1, 5'd2, 5'd28, 32'hFFFFFFFC, 1, 0, 0, 32'h124), 1);
    send(32'h001000EF, 32'h128, e(4'h0, 5'd0, 5'd1, 5'd1, 32'h800, 0, 0, 0, 32'h128), 1);
    send(32'hFFFFF117, 32'h12C, e(4'h0, 5'd31, 5'd31, 5'd2, 32'hFFFFF000, 1, 1, 0, 32'h12C), 1);
    send(32'h4020D1B3, 32'h130, e(4'hd, 5'd1, 5'd2, 5'd3, 32'h0, 0, 0, 0, 32'h130), 1);
    repeat (2) @(posedge clk);
    #1;
    // stall: output must hold for three cycles, then transfer exactly once
    out_ready = 1'b0;
    ha = e(4'h0, 5'd1, 5'd2, 5'd3, 32'h0, 0, 0, 0, 32'h200);
    send(32'h002081B3, 32'h200, ha, 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_hold", 128'(act), 128'(ha));
      chk("stall_valid", 128'(out_valid), 128'(1));
`ifndef IDECODE_SKID_EN
      chk("stall_ready", 128'(in_ready), 128'(0));
`endif
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // flush while stalled with a new word presented: neither is emitted
    out_ready = 1'b0;
    send(32'h402081B3, 32'h300, e(4'h8, 5'd1, 5'd2, 5'd3, 32'h0, 0, 0, 0, 32'h300), 0);
    in_valid = 1'b1;
    in_instr = 32'h40335293;
    in_pc    = 32'h304;
    flush    = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", 128'(out_valid), 128'(0));
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // reset during a stall discards the held word with no transfer
    out_ready = 1'b0;
    send(32'hFFF00093, 32'h400, e(4'h0, 5'd0, 5'd31, 5'd1, 32'hFFFFFFFF, 1, 0, 0, 32'h400), 0);
    rst       = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_no_xfer", 128'(out_valid), 128'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
`ifdef IDECODE_SKID_EN
    out_ready = 1'b0;
    send(32'h002081B3, 32'h500, e(4'h0, 5'd1, 5'd2, 5'd3, 32'h0, 0, 0, 0, 32'h500), 1);
    send(32'h402081B3, 32'h504, e(4'h8, 5'd1, 5'd2, 5'd3, 32'h0, 0, 0, 0, 32'h504), 1);
    @(negedge clk);
    chk("skid_full_ready", 128'(in_ready), 128'(0));
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
`endif
    repeat (3) @(posedge clk);
    chk("drain", 128'(q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
